flash_op_sequencer: RTL

Autonomous sequencer for slow flash operations: sector erase, block erase, chip erase and status-register write. It drives the command interface of the existing flash controller. For each operation it issues WRITE_ENABLE, then the operation command, then polls READ_SR until the WIP bit (SR[0]) clears or a poll budget runs out. It sits between the flash bus interface's control-register logic and the flash controller, so software starts an erase with one write and then watches a single busy/done/error status.

---
 rtl/flash_op_sequencer.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/flash_op_sequencer.sv
// Runs WREN, then an erase or WRSR command, then polls RDSR until WIP clears or the poll budget
// runs out. Every output is registered.
module flash_op_sequencer #(
  parameter int unsigned POLL_INTERVAL = 256,
  parameter int unsigned POLL_CNT_W    = 16,
  parameter int unsigned TIMEOUT_POLLS = 65535
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Start,
  input  logic [1:0]  i_Op,
  input  logic [23:0] i_Addr,
  input  logic [7:0]  i_SRData,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Error,
  output logic [7:0]  o_Status,
  output logic        o_CMDEn,
  output logic [2:0]  o_CMD,
  output logic [23:0] o_Addr,
  output logic [7:0]  o_WriteData,
  output logic        o_AckReq,
  input  logic        i_CMDBusy,
  input  logic        i_ReqNextData,
  input  logic        i_NewDataAvailableNextClk,
  input  logic [7:0]  i_ReadData
);

  localparam logic [2:0] CmdWren = 3'd0;
  localparam logic [2:0] CmdSe   = 3'd1;
  localparam logic [2:0] CmdBe   = 3'd2;
  localparam logic [2:0] CmdCe   = 3'd3;
  localparam logic [2:0] CmdRdsr = 3'd6;
  localparam logic [2:0] CmdWrsr = 3'd7;

  // POLL_ISSUE is itself one of the idle cycles, so the delay state covers POLL_INTERVAL-1.
  localparam bit              DelayNeeded = (POLL_INTERVAL > 1);
  localparam int unsigned     DlyW        = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [DlyW-1:0] DlyLast     = DlyW'((POLL_INTERVAL > 1) ? POLL_INTERVAL - 2 : 0);

  localparam logic [POLL_CNT_W-1:0] PollMax    = '1;
  localparam logic [POLL_CNT_W-1:0] TimeoutVal = POLL_CNT_W'(TIMEOUT_POLLS);

  typedef enum logic [3:0] {
    StIdle, StWrenIssue, StWrenWait, StOpIssue, StOpWait,
    StPollDelay, StPollIssue, StPollWait, StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [23:0]            addr_q, addr_d;
  logic [7:0]             srdata_q, srdata_d;
  logic [POLL_CNT_W-1:0]  poll_cnt_q, poll_cnt_d;
  logic [DlyW-1:0]        dly_cnt_q, dly_cnt_d;
  logic                   first_q, first_d;
  logic                   nd_q;
  logic                   wip_q, wip_d;
  logic                   wip_now;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [7:0]             status_q, status_d;
  logic                   cmd_en_q, cmd_en_d;
  logic [2:0]             cmd_q, cmd_d;
  logic [23:0]            cmd_addr_q, cmd_addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   ack_req_q, ack_req_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    srdata_d   = srdata_q;
    poll_cnt_d = poll_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    first_d    = 1'b0;
    wip_d      = wip_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    status_d   = status_q;
    cmd_en_d   = 1'b0;
    cmd_d      = cmd_q;
    cmd_addr_d = cmd_addr_q;
    wdata_d    = wdata_q;
    ack_req_d  = ack_req_q;

    // A byte flagged last cycle is on i_ReadData now; use it directly for this cycle's decision.
    wip_now = nd_q ? i_ReadData[0] : wip_q;
    if (nd_q && (state_q == StPollWait)) begin
      status_d = i_ReadData;
      wip_d    = i_ReadData[0];
    end

    if (i_ReqNextData) ack_req_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_Start) begin
          op_d       = i_Op;
          addr_d     = i_Addr;
          srdata_d   = i_SRData;
          error_d    = 1'b0;
          poll_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = StWrenIssue;
        end
      end
      StWrenIssue: begin
        if (!i_CMDBusy) begin
          cmd_en_d   = 1'b1;
          cmd_d      = CmdWren;
          cmd_addr_d = '0;
          first_d    = 1'b1;
          state_d    = StWrenWait;
        end
      end
      StWrenWait: begin
        if (!first_q && !i_CMDBusy) state_d = StOpIssue;
      end
      StOpIssue: begin
        if (!i_CMDBusy) begin
          cmd_en_d = 1'b1;
          first_d  = 1'b1;
          state_d  = StOpWait;
          unique case (op_q)
            2'd0: begin cmd_d = CmdSe; cmd_addr_d = addr_q; end
            2'd1: begin cmd_d = CmdBe; cmd_addr_d = addr_q; end
            2'd2: begin cmd_d = CmdCe; cmd_addr_d = '0; end
            2'd3: begin
              cmd_d      = CmdWrsr;
              cmd_addr_d = '0;
              wdata_d    = srdata_q;
              ack_req_d  = 1'b1;
            end
          endcase
        end
      end
      StOpWait: begin
        if (!first_q && !i_CMDBusy) begin
          dly_cnt_d = '0;
          if (DelayNeeded) state_d = StPollDelay;
          else             state_d = StPollIssue;
        end
      end
      StPollDelay: begin
        if (dly_cnt_q == DlyLast) state_d = StPollIssue;
        else                      dly_cnt_d = dly_cnt_q + DlyW'(1);
      end
      StPollIssue: begin
        if (!i_CMDBusy) begin
          cmd_en_d   = 1'b1;
          cmd_d      = CmdRdsr;
          cmd_addr_d = '0;
          first_d    = 1'b1;
          wip_d      = 1'b1;  // a poll that returns no byte reads as still busy
          if (poll_cnt_q != PollMax) poll_cnt_d = poll_cnt_q + POLL_CNT_W'(1);
          state_d    = StPollWait;
        end
      end
      StPollWait: begin
        if (!first_q && !i_CMDBusy) begin
          if (!wip_now) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else if (poll_cnt_q == TimeoutVal) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            dly_cnt_d = '0;
            if (DelayNeeded) state_d = StPollDelay;
            else             state_d = StPollIssue;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      addr_q     <= '0;
      srdata_q   <= '0;
      poll_cnt_q <= '0;
      dly_cnt_q  <= '0;
      first_q    <= 1'b0;
      nd_q       <= 1'b0;
      wip_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      status_q   <= '0;
      cmd_en_q   <= 1'b0;
      cmd_q      <= '0;
      cmd_addr_q <= '0;
      wdata_q    <= '0;
      ack_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      srdata_q   <= srdata_d;
      poll_cnt_q <= poll_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      first_q    <= first_d;
      nd_q       <= i_NewDataAvailableNextClk;
      wip_q      <= wip_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      status_q   <= status_d;
      cmd_en_q   <= cmd_en_d;
      cmd_q      <= cmd_d;
      cmd_addr_q <= cmd_addr_d;
      wdata_q    <= wdata_d;
      ack_req_q  <= ack_req_d;
    end
  end

  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_Error     = error_q;
  assign o_Status    = status_q;
  assign o_CMDEn     = cmd_en_q;
  assign o_CMD       = cmd_q;
  assign o_Addr      = cmd_addr_q;
  assign o_WriteData = wdata_q;
  assign o_AckReq    = ack_req_q;

endmodule
